// File: rtl/spi_packet_rx_if.sv
// Bundles the serial inputs from the off-chip controller together with the
// received-frame outputs that feed the command/parameter decode logic.
interface spi_packet_rx_if #(
  parameter int PACKET_BITS = 24
);
  logic                   cs;
  logic                   sck;
  logic                   sdi;
  logic [PACKET_BITS-1:0] packet;
  logic                   packet_valid;
  logic                   frame_error;
  logic                   busy;

  // Controller side: drives the serial lines and observes the result.
  modport master (
    output cs, sck, sdi,
    input  packet, packet_valid, frame_error, busy
  );

  // Receiver side.
  modport slave (
    input  cs, sck, sdi,
    output packet, packet_valid, frame_error, busy
  );
endinterface

// File: rtl/spi_packet_rx.sv
// SPI peripheral-side receiver for 24-bit control packets.
// cs/sck/sdi are oversampled in the clk domain; sdi is shifted in MSB first on
// each synchronised sck rising edge. A frame with exactly PACKET_BITS bits is
// delivered as a held word plus a one-cycle packet_valid; any other bit count
// gives a one-cycle frame_error and leaves packet untouched.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_IDLE | after reset: wait for synchronisers to fill and cs to be low
// IDLE      | between frames, waiting for cs rising edge
// SHIFT     | frame active, shifting sdi on sck rising edges (busy=1)
module spi_packet_rx #(
  parameter int PACKET_BITS = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  spi_packet_rx_if.slave   bus
);

  localparam int CW = $clog2(PACKET_BITS + 2);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_FULL    = CW'(PACKET_BITS);
  localparam logic [CW-1:0] CNT_SAT     = CW'(PACKET_BITS + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic                   d_cs, d_sck;
  logic                   s_cs, s_sck, s_sdi;
  logic                   cs_rise, cs_fall, sck_rise;

  logic [SW-1:0]          settle;
  logic                   settle_done;

  logic [PACKET_BITS-1:0] shreg, shreg_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   capture, error;

  logic [PACKET_BITS-1:0] packet_q;
  logic                   valid_pend, error_pend;
  logic                   packet_valid_q, frame_error_q;

  assign s_cs  = cs_sync[SYNC_STAGES-1];
  assign s_sck = sck_sync[SYNC_STAGES-1];
  assign s_sdi = sdi_sync[SYNC_STAGES-1];

  assign cs_rise  = s_cs & ~d_cs;
  assign cs_fall  = ~s_cs & d_cs;
  assign sck_rise = s_sck & ~d_sck;

  // Input synchronisers plus one extra stage on cs/sck for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
      d_cs     <= 1'b0;
      d_sck    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      d_cs     <= s_cs;
      d_sck    <= s_sck;
    end
  end

  // The sync flops clear to 0 on reset, so s_cs reads low until the chain has
  // refilled. This down-counter holds WAIT_IDLE until s_cs reflects the real
  // pin, otherwise a frame already in flight would look like a fresh cs rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      settle <= SETTLE_LOAD;
    else if (!settle_done)
      settle <= settle - SW'(1);
  end

  assign settle_done = (settle == '0);

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; a coincident sck rise is shifted and counted before the
  // cs fall evaluates the bit count.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    capture = 1'b0;
    error   = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (settle_done && !s_cs)
          state_n = IDLE;
      end
      IDLE: begin
        if (cs_rise) begin
          shreg_n = '0;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shreg_n = {shreg[PACKET_BITS-2:0], s_sdi};
          if (cnt != CNT_SAT)
            cnt_n = cnt + CW'(1);
        end
        if (cs_fall) begin
          state_n = IDLE;
          if (cnt_n == CNT_FULL)
            capture = 1'b1;
          else
            error = 1'b1;
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  // Capture the word when the frame closes and strobe one cycle later. The
  // word is taken at close time so a quick cs re-rise clearing shreg can't
  // corrupt it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      packet_q       <= '0;
      valid_pend     <= 1'b0;
      error_pend     <= 1'b0;
      packet_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      if (capture)
        packet_q <= shreg_n;
      valid_pend     <= capture;
      error_pend     <= error;
      packet_valid_q <= valid_pend;
      frame_error_q  <= error_pend;
    end
  end

  assign bus.packet       = packet_q;
  assign bus.packet_valid = packet_valid_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.busy         = (state == SHIFT);

endmodule

// File: tb/tb_spi_packet_rx.sv
// Directed bench for spi_packet_rx: drives SPI frames (sck period 8 clk) and
// checks held packet, strobe counts, busy and strobe latency.
module tb_spi_packet_rx;

  logic clk = 1'b0;
  logic reset;

  spi_packet_rx_if #(.PACKET_BITS(24)) bus ();

  spi_packet_rx #(.PACKET_BITS(24), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int   vcnt = 0;
  int   ecnt = 0;
  logic both_hi = 1'b0;
  logic wide    = 1'b0;
  logic prev_v  = 1'b0;
  logic prev_e  = 1'b0;
  logic busy_mid;

  // Strobe monitor: counts pulses and flags overlap or multi-cycle pulses.
  always @(negedge clk) begin
    if (bus.packet_valid) vcnt++;
    if (bus.frame_error)  ecnt++;
    if (bus.packet_valid && bus.frame_error) both_hi = 1'b1;
    if ((bus.packet_valid && prev_v) || (bus.frame_error && prev_e)) wide = 1'b1;
    prev_v = bus.packet_valid;
    prev_e = bus.frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.cs = 1'b1;
    tick(4);
  endtask

  // Sends bits data[hi] down to data[lo], MSB first; records busy at lo.
  task automatic send_bits(input logic [31:0] data, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.sdi = data[i];
      tick(4);
      bus.sck = 1'b1;
      tick(4);
      bus.sck = 1'b0;
      if (i == lo) busy_mid = bus.busy;
    end
  endtask

  task automatic end_frame(input int gap);
    tick(4);
    bus.cs = 1'b0;
    tick(gap);
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits);
    start_frame();
    send_bits(data, nbits - 1, 0);
    end_frame(12);
  endtask

  int  v0, e0, n;
  logic seen;

  initial begin
    reset   = 1'b1;
    bus.cs  = 1'b0;
    bus.sck = 1'b0;
    bus.sdi = 1'b0;
    tick(3);
    check("reset_packet", {8'h0, bus.packet}, 32'h0);
    check("reset_valid", {31'h0, bus.packet_valid}, 32'h0);
    check("reset_error", {31'h0, bus.frame_error}, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    reset = 1'b0;
    tick(10);

    // 1: single good frame
    v0 = vcnt; e0 = ecnt;
    start_frame();
    send_bits(32'h000114FF, 23, 0);
    check("t1_busy_in_frame", {31'h0, busy_mid}, 32'h1);
    end_frame(12);
    check("t1_packet", {8'h0, bus.packet}, 32'h000114FF);
    check("t1_valid_count", vcnt - v0, 1);
    check("t1_error_count", ecnt - e0, 0);
    check("t1_busy_after", {31'h0, bus.busy}, 32'h0);

    // 2: back-to-back frames with 2-clk gap
    v0 = vcnt; e0 = ecnt;
    start_frame();
    send_bits(32'h000114FF, 23, 0);
    end_frame(2);
    start_frame();
    send_bits(32'h00A5C30F, 23, 0);
    end_frame(12);
    check("t2_packet", {8'h0, bus.packet}, 32'h00A5C30F);
    check("t2_valid_count", vcnt - v0, 2);
    check("t2_error_count", ecnt - e0, 0);

    // 3: short then long frame, after restoring packet to 0114FF
    send_frame(32'h000114FF, 24);
    check("t3_prep_packet", {8'h0, bus.packet}, 32'h000114FF);
    v0 = vcnt; e0 = ecnt;
    send_frame(32'h00123457, 23);
    check("t3_short_error", ecnt - e0, 1);
    check("t3_short_packet", {8'h0, bus.packet}, 32'h000114FF);
    send_frame(32'h01ABCDEF, 25);
    check("t3_long_error", ecnt - e0, 2);
    check("t3_long_packet", {8'h0, bus.packet}, 32'h000114FF);
    check("t3_valid_count", vcnt - v0, 0);

    // 4: reset mid-frame, then finish that frame; it must be ignored
    v0 = vcnt; e0 = ecnt;
    start_frame();
    send_bits(32'h00123456, 23, 12);
    reset = 1'b1;
    tick(2);
    check("t4_reset_packet", {8'h0, bus.packet}, 32'h0);
    reset = 1'b0;
    send_bits(32'h00123456, 11, 0);
    check("t4_busy_rest_of_frame", {31'h0, busy_mid}, 32'h0);
    end_frame(12);
    check("t4_no_valid", vcnt - v0, 0);
    check("t4_no_error", ecnt - e0, 0);
    check("t4_packet_held", {8'h0, bus.packet}, 32'h0);
    send_frame(32'h000000AA, 24);
    check("t4_next_packet", {8'h0, bus.packet}, 32'h000000AA);
    check("t4_next_valid", vcnt - v0, 1);

    // 5: stray sck with cs low
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 10; i++) begin
      bus.sdi = i[0];
      tick(4);
      bus.sck = 1'b1;
      tick(4);
      bus.sck = 1'b0;
    end
    tick(8);
    check("t5_stray_no_strobe", (vcnt - v0) + (ecnt - e0), 0);
    check("t5_stray_busy", {31'h0, bus.busy}, 32'h0);
    send_frame(32'h00FFFFFF, 24);
    check("t5_packet", {8'h0, bus.packet}, 32'h00FFFFFF);
    check("t5_valid_count", vcnt - v0, 1);

    // 6: last sck rise coincident with cs fall; measure strobe latency
    v0 = vcnt; e0 = ecnt;
    start_frame();
    send_bits(32'h00800001, 23, 1);
    bus.sdi = 1'b1;
    tick(4);
    bus.sck = 1'b1;
    bus.cs  = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.packet_valid) seen = 1'b1;
    end
    check("t6_valid_seen", {31'h0, seen}, 32'h1);
    check("t6_latency_in_window", {31'h0, (n >= 4 && n <= 5)}, 32'h1);
    tick(4);
    bus.sck = 1'b0;
    tick(10);
    check("t6_packet", {8'h0, bus.packet}, 32'h00800001);
    check("t6_valid_count", vcnt - v0, 1);
    check("t6_error_count", ecnt - e0, 0);

    check("strobes_never_overlap", {31'h0, both_hi}, 32'h0);
    check("strobes_one_cycle", {31'h0, wide}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
